// File: rtl/fw_cmd_decoder_pkg.sv
// Shared types, field positions and index helpers for the firmware command decoder.
package fw_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE_CMD,
    RUN_CMD,
    SOFT_RST_CMD
  } state_t_sm_cmd_dec;

  typedef enum logic [3:0] {
    OP_NOOP              = 4'h0,
    OP_W_RST_FW          = 4'h1,
    OP_W_CFG_STATIC_0    = 4'h2,
    OP_R_CFG_STATIC_0    = 4'h3,
    OP_W_CFG_STATIC_1    = 4'h4,
    OP_R_CFG_STATIC_1    = 4'h5,
    OP_W_ARRAY_0         = 4'h6,
    OP_R_ARRAY_0         = 4'h7,
    OP_W_ARRAY_1         = 4'h8,
    OP_R_ARRAY_1         = 4'h9,
    OP_W_ARRAY_2         = 4'hA,
    OP_R_ARRAY_2         = 4'hB,
    OP_R_DATA_ARRAY_0    = 4'hC,
    OP_R_DATA_ARRAY_1    = 4'hD,
    OP_W_STATUS_FW_CLEAR = 4'hE,
    OP_W_EXECUTE         = 4'hF
  } op_code_e;

  localparam int DEV_ID_MSB = 31;
  localparam int DEV_ID_LSB = 28;
  localparam int OP_MSB     = 27;
  localparam int OP_LSB     = 24;
  localparam int BODY_MSB   = 23;
  localparam int BODY_LSB   = 0;

  localparam int ST_RST_FW     = 0;
  localparam int ST_EXECUTE    = 13;
  localparam int ST_DONE_FIRST = 14;
  localparam int ST_ERR        = 31;

  // Bits 19..30 are spare and must never become set.
  localparam logic [31:0] STATUS_IMPL_MASK = 32'h8007_FFFF;

  // Test code -> status bit of its done flag; 0 means the code has no done line.
  function automatic logic [4:0] status_idx_of_code(input logic [3:0] code);
    case (code)
      4'd1:    status_idx_of_code = 5'd14;
      4'd2:    status_idx_of_code = 5'd15;
      4'd4:    status_idx_of_code = 5'd16;
      4'd8:    status_idx_of_code = 5'd17;
      4'd3:    status_idx_of_code = 5'd18;
      default: status_idx_of_code = 5'd0;
    endcase
  endfunction

  // Ops 2h..Dh occupy status bits 1..12 in opcode order; execute owns bit 13.
  function automatic logic [4:0] status_idx_of_op(input logic [3:0] op);
    if (op == 4'hF) status_idx_of_op = 5'd13;
    else            status_idx_of_op = {1'b0, op} - 5'd1;
  endfunction

  // Writes that would disturb a running test.
  function automatic logic is_run_locked(input logic [3:0] op);
    case (op)
      4'h2, 4'h4, 4'h6, 4'h8, 4'hA: is_run_locked = 1'b1;
      default:                      is_run_locked = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fw_status_reg.sv
// 32-bit sticky status register: a clear pulse wipes it, set bits always win over the clear.
module fw_status_reg
  import fw_cmd_decoder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] set_i,
  input  logic        clr_i,
  output logic [31:0] status_o
);

  logic [31:0] status_q;
  logic [31:0] status_d;

  always_comb begin
    status_d = clr_i ? 32'h0 : status_q;
    status_d = (status_d | set_i) & STATUS_IMPL_MASK;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) status_q <= 32'h0;
    else          status_q <= status_d;
  end

  assign status_o = status_q;

endmodule

// File: rtl/fw_cmd_decoder.sv
// Host command front-end: device_id filter, config/status registers and test arbitration.
// Handshake: a command is consumed on any edge where cmd_valid and cmd_ready are both high.
module fw_cmd_decoder
  import fw_cmd_decoder_pkg::*;
#(
  parameter logic [3:0]  FIRMWARE_ID     = 4'h2,
  parameter int          TEST_NUM_MIN    = 12,
  parameter logic [15:0] VALID_TEST_MASK = 16'h011E,
  parameter int          RST_CYCLES      = 16
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_word,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [23:0] cfg_static_0_reg,
  output logic [23:0] cfg_static_1_reg,
  output logic [23:0] exec_cfg_reg,
  output logic        test_start,
  output logic [3:0]  test_number,
  output logic        test_busy,
  input  logic [4:0]  test_done,
  output logic        arr_req,
  output logic [3:0]  arr_op,
  output logic [23:0] arr_body,
  output logic        fw_soft_rst_n,
  output logic [31:0] status_reg
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t_sm_cmd_dec state_q;
  logic              cmd_ready_q;
  logic              soft_rst_n_q;
  logic              rd_valid_q;
  logic [31:0]       rd_data_q;
  logic [23:0]       cfg0_q;
  logic [23:0]       cfg1_q;
  logic [23:0]       exec_cfg_q;
  logic              test_start_q;
  logic [3:0]        test_number_q;
  logic              test_busy_q;
  logic              arr_req_q;
  logic [3:0]        arr_op_q;
  logic [23:0]       arr_body_q;
  logic [CNT_W-1:0]  rst_cnt_q;

  logic [3:0]  cmd_dev;
  logic [3:0]  cmd_op_raw;
  op_code_e    cmd_op;
  logic [23:0] cmd_body;
  logic [3:0]  exec_code;
  logic        cmd_hit;
  logic        in_run;
  logic        exec_ok;
  logic        rst_fw;
  logic [4:0]  done_idx;
  logic [31:0] done_vec;
  logic        done_hit;
  logic [31:0] st_set;
  logic        st_clr;

  assign cmd_dev    = cmd_word[DEV_ID_MSB:DEV_ID_LSB];
  assign cmd_op_raw = cmd_word[OP_MSB:OP_LSB];
  assign cmd_op     = op_code_e'(cmd_op_raw);
  assign cmd_body   = cmd_word[BODY_MSB:BODY_LSB];
  assign exec_code  = cmd_word[TEST_NUM_MIN+3 -: 4];

  assign cmd_hit  = cmd_valid && cmd_ready_q && (FIRMWARE_ID != 4'h0) && (cmd_dev == FIRMWARE_ID);
  assign in_run   = (state_q == RUN_CMD);
  assign exec_ok  = (state_q == IDLE_CMD) && VALID_TEST_MASK[exec_code];
  assign rst_fw   = cmd_hit && (cmd_op == OP_W_RST_FW);

  // Done pulses are laid onto the status bit positions so the active code picks its own line.
  assign done_idx = status_idx_of_code(test_number_q);
  assign done_vec = {13'b0, test_done, 14'b0};
  assign done_hit = in_run && (done_idx != 5'd0) && done_vec[done_idx];

  always_comb begin
    st_set = 32'h0;
    st_clr = 1'b0;
    if (cmd_hit) begin
      case (cmd_op)
        OP_NOOP: begin end
        OP_W_RST_FW: begin
          st_clr            = 1'b1;
          st_set[ST_RST_FW] = 1'b1;
        end
        OP_W_STATUS_FW_CLEAR: st_clr = 1'b1;
        OP_W_EXECUTE: begin
          st_set[ST_EXECUTE] = 1'b1;
          if (!exec_ok) st_set[ST_ERR] = 1'b1;
        end
        default: begin
          if (in_run && is_run_locked(cmd_op_raw)) st_set[ST_ERR] = 1'b1;
          else                                     st_set[status_idx_of_op(cmd_op_raw)] = 1'b1;
        end
      endcase
    end
    // An aborting soft reset hides the done of the test it kills.
    if (done_hit && !rst_fw) st_set[done_idx] = 1'b1;
  end

  fw_status_reg u_status (
    .clk_i    (fw_axi_clk),
    .rst_n_i  (fw_rst_n),
    .set_i    (st_set),
    .clr_i    (st_clr),
    .status_o (status_reg)
  );

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q       <= IDLE_CMD;
      cmd_ready_q   <= 1'b1;
      soft_rst_n_q  <= 1'b1;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 32'h0;
      cfg0_q        <= 24'h0;
      cfg1_q        <= 24'h0;
      exec_cfg_q    <= 24'h0;
      test_start_q  <= 1'b0;
      test_number_q <= 4'h0;
      test_busy_q   <= 1'b0;
      arr_req_q     <= 1'b0;
      arr_op_q      <= 4'h0;
      arr_body_q    <= 24'h0;
      rst_cnt_q     <= '0;
    end else begin
      test_start_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      arr_req_q    <= 1'b0;
      case (state_q)
        IDLE_CMD, RUN_CMD: begin
          if (done_hit) begin
            state_q       <= IDLE_CMD;
            test_number_q <= 4'h0;
            test_busy_q   <= 1'b0;
          end
          if (cmd_hit) begin
            case (cmd_op)
              OP_W_RST_FW: begin
                state_q       <= SOFT_RST_CMD;
                cmd_ready_q   <= 1'b0;
                soft_rst_n_q  <= 1'b0;
                rst_cnt_q     <= CNT_W'(RST_CYCLES - 1);
                cfg0_q        <= 24'h0;
                cfg1_q        <= 24'h0;
                exec_cfg_q    <= 24'h0;
                test_number_q <= 4'h0;
                test_busy_q   <= 1'b0;
              end
              OP_W_CFG_STATIC_0: if (!in_run) cfg0_q <= cmd_body;
              OP_W_CFG_STATIC_1: if (!in_run) cfg1_q <= cmd_body;
              OP_R_CFG_STATIC_0: begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= {FIRMWARE_ID, cmd_op_raw, cfg0_q};
              end
              OP_R_CFG_STATIC_1: begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= {FIRMWARE_ID, cmd_op_raw, cfg1_q};
              end
              OP_W_EXECUTE: begin
                if (exec_ok) begin
                  state_q       <= RUN_CMD;
                  exec_cfg_q    <= cmd_body;
                  test_number_q <= exec_code;
                  test_start_q  <= 1'b1;
                  test_busy_q   <= 1'b1;
                end
              end
              OP_NOOP, OP_W_STATUS_FW_CLEAR: begin end
              default: begin
                if (!(in_run && is_run_locked(cmd_op_raw))) begin
                  arr_req_q  <= 1'b1;
                  arr_op_q   <= cmd_op_raw;
                  arr_body_q <= cmd_body;
                end
              end
            endcase
          end
        end
        SOFT_RST_CMD: begin
          if (rst_cnt_q == '0) begin
            state_q      <= IDLE_CMD;
            soft_rst_n_q <= 1'b1;
            cmd_ready_q  <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE_CMD;
      endcase
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
  assign cfg_static_0_reg = cfg0_q;
  assign cfg_static_1_reg = cfg1_q;
  assign exec_cfg_reg     = exec_cfg_q;
  assign test_start       = test_start_q;
  assign test_number      = test_number_q;
  assign test_busy        = test_busy_q;
  assign arr_req          = arr_req_q;
  assign arr_op           = arr_op_q;
  assign arr_body         = arr_body_q;
  // Held low throughout the hard reset, independent of any clock.
  assign fw_soft_rst_n    = soft_rst_n_q & fw_rst_n;

endmodule

// File: tb/tb_fw_cmd_decoder.sv
// Bench for fw_cmd_decoder: vector table for single commands, hand sequences for test runs and soft reset.
module tb_fw_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_word = 32'h0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [23:0] cfg0, cfg1, exec_cfg;
  logic        test_start;
  logic [3:0]  test_number;
  logic        test_busy;
  logic [4:0]  test_done = 5'h0;
  logic        arr_req;
  logic [3:0]  arr_op;
  logic [23:0] arr_body;
  logic        fw_soft_rst_n;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [27:0] arr_q[$];

  always #5 clk = ~clk;

  fw_cmd_decoder dut (
    .fw_axi_clk       (clk),
    .fw_rst_n         (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_word         (cmd_word),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .cfg_static_0_reg (cfg0),
    .cfg_static_1_reg (cfg1),
    .exec_cfg_reg     (exec_cfg),
    .test_start       (test_start),
    .test_number      (test_number),
    .test_busy        (test_busy),
    .test_done        (test_done),
    .arr_req          (arr_req),
    .arr_op           (arr_op),
    .arr_body         (arr_body),
    .fw_soft_rst_n    (fw_soft_rst_n),
    .status_reg       (status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive a command and/or done pulse, return just after the edge that consumed it.
  task automatic step(input logic [31:0] w, input logic v, input logic [4:0] d);
    cmd_word  = w;
    cmd_valid = v;
    test_done = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    test_done = 5'h0;
  endtask

  task automatic wait_soft(input logic [4:0] done_pulse, output int n);
    n = 0;
    while (fw_soft_rst_n == 1'b0 && n < 40) begin
      chk("soft_cmd_ready_low", {31'h0, cmd_ready}, 32'h0);
      test_done = (n == 0) ? done_pulse : 5'h0;
      n++;
      @(posedge clk);
      #1;
    end
    test_done = 5'h0;
    chk("soft_cmd_ready_back", {31'h0, cmd_ready}, 32'h1);
  endtask

  // Scoreboard side: read responses and array strobes are matched against queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", rd_data, 32'hFFFF_FFFF);
        else                   chk("rd_data", rd_data, exp_q.pop_front());
      end
      if (arr_req) begin
        if (arr_q.size() == 0) chk("arr_unexpected", {4'h0, arr_op, arr_body}, 32'hFFFF_FFFF);
        else                   chk("arr_req", {4'h0, arr_op, arr_body}, {4'h0, arr_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_status;
    logic [23:0] exp_cfg0;
    logic [23:0] exp_cfg1;
    logic        exp_rd;
    logic [31:0] exp_rd_data;
    logic        exp_arr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    vecs[0]  = '{32'h22ABCDEF, 32'h0000_0002, 24'hABCDEF, 24'h000000, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{32'h23000000, 32'h0000_0006, 24'hABCDEF, 24'h000000, 1'b1, 32'h23ABCDEF, 1'b0};
    vecs[2]  = '{32'h12123456, 32'h0000_0006, 24'hABCDEF, 24'h000000, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{32'h24123456, 32'h0000_000E, 24'hABCDEF, 24'h123456, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{32'h25000000, 32'h0000_001E, 24'hABCDEF, 24'h123456, 1'b1, 32'h25123456, 1'b0};
    vecs[5]  = '{32'h27000055, 32'h0000_005E, 24'hABCDEF, 24'h123456, 1'b0, 32'h0,         1'b1};
    vecs[6]  = '{32'h2E000000, 32'h0000_0000, 24'hABCDEF, 24'h123456, 1'b0, 32'h0,         1'b0};
    vecs[7]  = '{32'h2F005000, 32'h8000_2000, 24'hABCDEF, 24'h123456, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{32'h2E000000, 32'h0000_0000, 24'hABCDEF, 24'h123456, 1'b0, 32'h0,         1'b0};
    vecs[9]  = '{32'h20000000, 32'h0000_0000, 24'hABCDEF, 24'h123456, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{32'h2D000001, 32'h0000_1000, 24'hABCDEF, 24'h123456, 1'b0, 32'h0,         1'b1};
    vecs[11] = '{32'h2E000000, 32'h0000_0000, 24'hABCDEF, 24'h123456, 1'b0, 32'h0,         1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_soft_rst_n", {31'h0, fw_soft_rst_n}, 32'h0);
    chk("rst_status", status, 32'h0);
    chk("rst_busy", {31'h0, test_busy}, 32'h0);
    chk("rst_test_number", {28'h0, test_number}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_soft_rst_n", {31'h0, fw_soft_rst_n}, 32'h1);
    @(posedge clk);
    #1;

    // Single-command vectors, all from IDLE
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].exp_rd)  exp_q.push_back(vecs[i].exp_rd_data);
      if (vecs[i].exp_arr) arr_q.push_back(vecs[i].word[27:0]);
      step(vecs[i].word, 1'b1, 5'h0);
      chk($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
      chk($sformatf("vec%0d_cfg0", i), {8'h0, cfg0}, {8'h0, vecs[i].exp_cfg0});
      chk($sformatf("vec%0d_cfg1", i), {8'h0, cfg1}, {8'h0, vecs[i].exp_cfg1});
      chk($sformatf("vec%0d_start", i), {31'h0, test_start}, 32'h0);
      chk($sformatf("vec%0d_ready", i), {31'h0, cmd_ready}, 32'h1);
    end

    // Test 2 runs to completion; a done on another line is ignored
    step(32'h2F002000, 1'b1, 5'h0);
    chk("exec2_start", {31'h0, test_start}, 32'h1);
    chk("exec2_busy", {31'h0, test_busy}, 32'h1);
    chk("exec2_number", {28'h0, test_number}, 32'h2);
    chk("exec2_cfg", {8'h0, exec_cfg}, 32'h0000_2000);
    chk("exec2_status", status, 32'h0000_2000);
    step(32'h0, 1'b0, 5'b00001);
    chk("exec2_start_pulse", {31'h0, test_start}, 32'h0);
    chk("exec2_wrong_done", {31'h0, test_busy}, 32'h1);
    step(32'h0, 1'b0, 5'b00010);
    chk("done2_status", status, 32'h0000_A000);
    chk("done2_busy", {31'h0, test_busy}, 32'h0);
    chk("done2_number", {28'h0, test_number}, 32'h0);
    step(32'h2E000000, 1'b1, 5'h0);

    // Rejections while test 1 runs, then clear and done together
    step(32'h2F001000, 1'b1, 5'h0);
    chk("exec1_number", {28'h0, test_number}, 32'h1);
    step(32'h26000001, 1'b1, 5'h0);
    chk("run_arr_write", status, 32'h8000_2000);
    step(32'h22111111, 1'b1, 5'h0);
    chk("run_cfg0_kept", {8'h0, cfg0}, 32'h00AB_CDEF);
    arr_q.push_back(28'h9000077);
    step(32'h29000077, 1'b1, 5'h0);
    chk("run_arr_read", status, 32'h8000_2100);
    step(32'h2F002000, 1'b1, 5'h0);
    chk("run_exec_number", {28'h0, test_number}, 32'h1);
    chk("run_exec_nostart", {31'h0, test_start}, 32'h0);
    chk("run_exec_cfg", {8'h0, exec_cfg}, 32'h0000_1000);
    step(32'h2E000000, 1'b1, 5'b00001);
    chk("clr_done_status", status, 32'h0000_4000);
    chk("clr_done_busy", {31'h0, test_busy}, 32'h0);

    // Execute in the same cycle as the completing done is rejected
    step(32'h2F004000, 1'b1, 5'h0);
    chk("exec4_status", status, 32'h0000_6000);
    step(32'h2F001000, 1'b1, 5'b00100);
    chk("exec_vs_done_status", status, 32'h8001_6000);
    chk("exec_vs_done_busy", {31'h0, test_busy}, 32'h0);
    chk("exec_vs_done_start", {31'h0, test_start}, 32'h0);
    chk("exec_vs_done_cfg", {8'h0, exec_cfg}, 32'h0000_4000);

    // Soft reset aborts test 8; a late done is ignored
    step(32'h2F008000, 1'b1, 5'h0);
    chk("exec8_busy", {31'h0, test_busy}, 32'h1);
    step(32'h21000000, 1'b1, 5'h0);
    chk("srst_status", status, 32'h0000_0001);
    chk("srst_cfg0", {8'h0, cfg0}, 32'h0);
    chk("srst_cfg1", {8'h0, cfg1}, 32'h0);
    chk("srst_exec_cfg", {8'h0, exec_cfg}, 32'h0);
    chk("srst_busy", {31'h0, test_busy}, 32'h0);
    wait_soft(5'b01000, n);
    chk("srst_low_cycles", n, 32'd16);
    chk("srst_status_after", status, 32'h0000_0001);

    // Soft reset in the same cycle as the done of test 3
    step(32'h2F003000, 1'b1, 5'h0);
    chk("exec3_number", {28'h0, test_number}, 32'h3);
    step(32'h21000000, 1'b1, 5'b10000);
    chk("srst_vs_done_status", status, 32'h0000_0001);
    wait_soft(5'h0, n);
    chk("srst2_low_cycles", n, 32'd16);

    // Random wrong-device traffic must be inert
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[31:28] = 4'($urandom_range(3, 15));
      step(w, 1'b1, 5'h0);
    end
    chk("foreign_status", status, 32'h0000_0001);
    chk("foreign_busy", {31'h0, test_busy}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_drained", exp_q.size(), 32'd0);
    chk("arr_queue_drained", arr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fw_cmd_decoder.md
# fw_cmd_decoder

Command front-end for one firmware IP (fw_ip1 or fw_ip2). It accepts 32-bit host command words `{device_id[31:28], op_code[27:24], body[23:0]}` and filters them on device_id. It owns the static configuration registers, the execute-configuration register and the 32-bit status register, and it arbitrates test execution. It sits directly upstream of the test state machines: it feeds them configuration, a start pulse and a soft reset, and it consumes their done pulses.

## Interface
Parameters:
- FIRMWARE_ID, 4'h2: device_id value this instance answers to. 4'h0 (none) never matches.
- TEST_NUM_MIN, 12: low bit of the test-number field in body. Use 14 for IP1.
- VALID_TEST_MASK, 16'h011E: bit n set means test code n is legal. Default is codes 1, 2, 3, 4, 8. Use 16'h0006 for IP1.
- RST_CYCLES, 16: soft-reset pulse length in clocks, minimum 1.

Ports:
- fw_axi_clk  in  1  sole clock.
- fw_rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command word present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high.
- cmd_word  in  32  command word.
- rd_valid  out  1  one-cycle read-response strobe.
- rd_data  out  32  read response `{FIRMWARE_ID, op_code, data[23:0]}`.
- cfg_static_0_reg  out  24  static config 0.
- cfg_static_1_reg  out  24  static config 1.
- exec_cfg_reg  out  24  body of the last accepted execute.
- test_start  out  1  one-cycle start pulse.
- test_number  out  4  active test code, 0 when idle.
- test_busy  out  1  high in RUN.
- test_done  in  5  done pulses for test codes 1, 2, 4, 8, 3, at bit indices 0..4.
- arr_req  out  1  one-cycle strobe for ops 6h..Dh.
- arr_op  out  4  op_code qualified by arr_req.
- arr_body  out  24  body qualified by arr_req.
- fw_soft_rst_n  out  1  active-low soft reset to the test engines.
- status_reg  out  32  sticky status, bit map below.

## Operation
State machine states: IDLE, RUN, SOFT_RST.
- A command is taken when cmd_valid is high and cmd_ready is high.
- cmd_ready is 0 only in SOFT_RST.
- A command whose device_id is not FIRMWARE_ID is consumed and has no effect.

Status bit map:
- bit 0: W_RST_FW accepted.
- bits 1..13: the accepted op in opcode order (W/R static 0/1, W/R array 0..2, R data array 0..1, W_EXECUTE).
- bits 14..18: test done for codes 1, 2, 4, 8, 3.
- bits 19..30: spare, read 0.
- bit 31: execute/config error.

Per op_code, for a matched command:
- 0h NOOP: no effect.
- 1h W_RST_FW, any state:
  - clears cfg_static_0, cfg_static_1, exec_cfg and status, then sets status bit 0;
  - enters SOFT_RST with fw_soft_rst_n=0 for RST_CYCLES clocks;
  - then returns to IDLE;
  - an in-flight test is aborted and its done is never flagged.
- 2h / 4h write static 0 / 1:
  - in IDLE: load body and set the status bit;
  - in RUN: register unchanged, set bit 31.
- 3h / 5h read static 0 / 1: rd_valid with the register in data, set the status bit. Allowed in any state that accepts commands.
- 6h..Dh array ops: pulse arr_req with arr_op and arr_body, set the status bit. In RUN, write ops (6h, 8h, Ah) are rejected with bit 31 set and no arr_req.
- Eh W_STATUS_FW_CLEAR: status becomes 0.
- Fh W_EXECUTE:
  - set bit 13;
  - the code is `body[TEST_NUM_MIN+3:TEST_NUM_MIN]`;
  - if in IDLE and the code is legal in VALID_TEST_MASK: load exec_cfg_reg, set test_number, pulse test_start, go to RUN;
  - otherwise (illegal code, or already in RUN): set bit 31, exec_cfg_reg and state unchanged.

In RUN:
- A test_done pulse on the index matching test_number sets that done status bit, clears test_number to 0 and returns to IDLE.
- Done pulses on other indices are ignored.
- In IDLE, test_done is ignored.

Simultaneous events:
- A command is evaluated against the state held at the start of the cycle. An execute in the same cycle as the completing done is therefore rejected with bit 31 set.
- Status clear and a done-bit set in the same cycle: the set wins.
- W_RST_FW in the same cycle as a done: the reset wins and the done bit stays 0.

## Timing
- All outputs are registered.
- Register and status updates, test_start, arr_req and rd_valid all appear 1 cycle after the accepting edge.
- busy/RUN is visible on the same edge as test_start.
- SOFT_RST is entered 1 cycle after W_RST_FW is accepted; fw_soft_rst_n is low for exactly RST_CYCLES cycles.
- cmd_ready rises on the cycle fw_soft_rst_n rises.
- Throughput: 1 command per clock outside SOFT_RST.
- Reset values: every register and output 0, state IDLE, with these exceptions:
  - cmd_ready = 1;
  - fw_soft_rst_n = 0 while fw_rst_n is low and 1 after release.

## Structure
- The shared package holds:
  - enum `state_t_sm_cmd_dec` {IDLE_CMD, RUN_CMD, SOFT_RST_CMD};
  - a function mapping test code to done/status index (1→14, 2→15, 4→16, 8→17, 3→18);
  - the existing op_code enum, status_index constants and field indices.
- Sub-module fw_status_reg: the 32-bit sticky set/clear register with set-over-clear priority.

## Test plan
- W_EXECUTE 0x2F002000 (IDLE, code 2) → test_start 1 cycle later, test_number=2, status bit 13 set; test_done[1] pulse → status 0x0000A000, IDLE.
- W_EXECUTE with code 5 → bit 31 set, no test_start; then W_STATUS_FW_CLEAR 0x2E000000 → status 0.
- W_CFG_STATIC_0 0x22ABCDEF then R_CFG_STATIC_0 0x23000000 → cfg_static_0_reg=0xABCDEF, rd_data=0x23ABCDEF, status 0x00000006.
- Command 0x12123456 (wrong device_id) → no register, status or strobe change; cmd_ready stays 1.
- In RUN, W_RST_FW → SOFT_RST next cycle, fw_soft_rst_n low 16 cycles, cmd_ready 0 throughout, status=0x00000001, later test_done ignored.
- test_done[0] and W_STATUS_FW_CLEAR in the same cycle during test 1 → status=0x00004000.
